// File: rtl/wptr_full_if.sv
// Write-side bus of the async FIFO: write request, overflow clear, synchronized
// read pointer in; RAM write port, published Gray pointer and status flags out.
interface wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  winc;
  logic                  clr_ovf;
  logic [ADDR_WIDTH:0]   sync_rptr;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  overflow;

  // Writer side: issues requests and supplies the synchronized read pointer.
  modport master (
    output winc, clr_ovf, sync_rptr,
    input  wen, waddr, wptr, full, almost_full, wlevel, overflow
  );

  // Pointer block side.
  modport slave (
    input  winc, clr_ovf, sync_rptr,
    output wen, waddr, wptr, full, almost_full, wlevel, overflow
  );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer and full-flag logic of the async FIFO. Keeps a binary and
// a Gray write pointer, drives the RAM write port, and derives full, almost_full,
// fill level and a sticky overflow flag from the read pointer that has already
// been synchronized into this clock domain. ADDR_WIDTH must be at least 2.
module wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14
) (
  input  logic        wclk,
  input  logic        w_rst,
  wptr_full_if.slave  bus
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] AF_LEVEL = (AW+1)'(AF_THRESH);

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wptr_q, wgray_d;
  logic [AW:0] wlevel_q, wlevel_d;
  logic [AW:0] rbin;
  logic [AW:0] full_cmp;
  logic        full_q, full_d;
  logic        af_q, af_d;
  logic        ovf_q, ovf_d;
  logic        accept;

  assign accept = bus.winc & ~full_q;

  // Next pointer values, read-pointer decode and the flag terms built from them.
  always_comb begin
    wbin_d  = wbin_q + {{AW{1'b0}}, accept};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    rbin    = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin[i] = ^(bus.sync_rptr >> i);
    end
    wlevel_d = wbin_d - rbin;
    af_d     = (wlevel_d >= AF_LEVEL);
    full_cmp = {~bus.sync_rptr[AW:AW-1], bus.sync_rptr[AW-2:0]};
    full_d   = (wgray_d == full_cmp);
  end

  // Overflow is sticky; a fresh dropped write takes priority over a clear request.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.winc && full_q) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; reset discards all pointer state regardless of other inputs.
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wlevel_q <= wlevel_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.wen         = accept;
  assign bus.waddr       = wbin_q[AW-1:0];
  assign bus.wptr        = wptr_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.wlevel      = wlevel_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full with ADDR_WIDTH=4, AF_THRESH=14.
module tb_wptr_full;

  logic wclk;
  logic w_rst;
  int   checks;
  int   errors;

  wptr_full_if #(.ADDR_WIDTH(4)) bus ();

  wptr_full #(.ADDR_WIDTH(4), .AF_THRESH(14)) dut (
    .wclk  (wclk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       winc;
    logic       clr;
    logic [4:0] rptr;
    logic       chkWen;
    logic       expWen;
    logic [3:0] expAddr;
    logic [4:0] expPtr;
    logic       expFull;
    logic       expAf;
    logic [4:0] expLvl;
    logic       expOvf;
  } vec_t;

  vec_t vecs[$];

  // Free-running write clock.
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  function automatic vec_t mk(input logic rst, input logic winc, input logic clr,
                              input logic [4:0] rptr, input logic chkWen, input logic expWen,
                              input logic [3:0] expAddr, input logic [4:0] expPtr,
                              input logic expFull, input logic expAf,
                              input logic [4:0] expLvl, input logic expOvf);
    vec_t v;
    v.rst = rst; v.winc = winc; v.clr = clr; v.rptr = rptr;
    v.chkWen = chkWen; v.expWen = expWen; v.expAddr = expAddr; v.expPtr = expPtr;
    v.expFull = expFull; v.expAf = expAf; v.expLvl = expLvl; v.expOvf = expOvf;
    return v;
  endfunction

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, let the next edge take them.
  task automatic applyStimulus(input logic rst, input logic winc, input logic clr,
                               input logic [4:0] rptr);
    w_rst         = rst;
    bus.winc      = winc;
    bus.clr_ovf   = clr;
    bus.sync_rptr = rptr;
    @(posedge wclk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [4:0] ptr, input logic [3:0] addr,
                          input logic full, input logic af, input logic [4:0] lvl,
                          input logic ovf);
    checkOutput({tag, " wptr"}, 32'(bus.wptr), 32'(ptr));
    checkOutput({tag, " waddr"}, 32'(bus.waddr), 32'(addr));
    checkOutput({tag, " full"}, 32'(bus.full), 32'(full));
    checkOutput({tag, " almost_full"}, 32'(bus.almost_full), 32'(af));
    checkOutput({tag, " wlevel"}, 32'(bus.wlevel), 32'(lvl));
    checkOutput({tag, " overflow"}, 32'(bus.overflow), 32'(ovf));
  endtask

  initial begin
    logic [4:0] prevPtr;
    int         rc;
    checks = 0;
    errors = 0;
    w_rst = 1'b0;
    bus.winc = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.sync_rptr = '0;

    // Reset held with winc=1, then fill 16 entries against an idle reader, then one dropped write.
    vecs.push_back(mk(1, 1, 0, 5'b00000, 0, 1, 4'd0,  5'b00000, 0, 0, 5'd0,  0));
    vecs.push_back(mk(1, 1, 0, 5'b00000, 1, 1, 4'd0,  5'b00000, 0, 0, 5'd0,  0));
    vecs.push_back(mk(1, 1, 0, 5'b00000, 1, 1, 4'd0,  5'b00000, 0, 0, 5'd0,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd1,  5'b00001, 0, 0, 5'd1,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd2,  5'b00011, 0, 0, 5'd2,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd3,  5'b00010, 0, 0, 5'd3,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd4,  5'b00110, 0, 0, 5'd4,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd5,  5'b00111, 0, 0, 5'd5,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd6,  5'b00101, 0, 0, 5'd6,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd7,  5'b00100, 0, 0, 5'd7,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd8,  5'b01100, 0, 0, 5'd8,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd9,  5'b01101, 0, 0, 5'd9,  0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd10, 5'b01111, 0, 0, 5'd10, 0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd11, 5'b01110, 0, 0, 5'd11, 0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd12, 5'b01010, 0, 0, 5'd12, 0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd13, 5'b01011, 0, 0, 5'd13, 0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd14, 5'b01001, 0, 1, 5'd14, 0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd15, 5'b01000, 0, 1, 5'd15, 0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 1, 4'd0,  5'b11000, 1, 1, 5'd16, 0));
    vecs.push_back(mk(0, 1, 0, 5'b00000, 1, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 1));
    vecs.push_back(mk(0, 0, 0, 5'b00000, 1, 0, 4'd0,  5'b11000, 1, 1, 5'd16, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      w_rst         = vecs[i].rst;
      bus.winc      = vecs[i].winc;
      bus.clr_ovf   = vecs[i].clr;
      bus.sync_rptr = vecs[i].rptr;
      @(negedge wclk);
      if (vecs[i].chkWen) begin
        checkOutput($sformatf("vec%0d wen", i), 32'(bus.wen), 32'(vecs[i].expWen));
      end
      @(posedge wclk);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].expPtr, vecs[i].expAddr, vecs[i].expFull,
               vecs[i].expAf, vecs[i].expLvl, vecs[i].expOvf);
    end

    // Overflow stays set through ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 5'b00000);
      checkOutput("ovf hold", 32'(bus.overflow), 32'd1);
    end
    applyStimulus(0, 0, 1, 5'b00000);
    checkOutput("ovf clear", 32'(bus.overflow), 32'd0);
    applyStimulus(0, 1, 1, 5'b00000);
    checkOutput("ovf beats clr", 32'(bus.overflow), 32'd1);
    checkOutput("ovf drop wptr", 32'(bus.wptr), 32'b11000);
    applyStimulus(0, 0, 1, 5'b00000);
    checkOutput("ovf clear2", 32'(bus.overflow), 32'd0);

    // Reader advances to binary 4: full drops, level falls to 12, next write lands at 0.
    applyStimulus(0, 0, 0, 5'b00110);
    checkAll("drain", 5'b11000, 4'd0, 0, 0, 5'd12, 0);
    bus.winc = 1'b1;
    @(negedge wclk);
    checkOutput("drain wen", 32'(bus.wen), 32'd1);
    checkOutput("drain waddr", 32'(bus.waddr), 32'd0);
    @(posedge wclk);
    #1;
    checkAll("drain write", 5'b11001, 4'd1, 0, 0, 5'd13, 0);

    // Reader trails the writer by two cycles across a full pointer wrap.
    applyStimulus(1, 0, 0, 5'b00000);
    applyStimulus(0, 0, 0, 5'b00000);
    checkOutput("wrap start", 32'(bus.wptr), 32'd0);
    prevPtr = 5'b00000;
    for (int k = 1; k <= 40; k++) begin
      rc = (k >= 3) ? k - 3 : 0;
      applyStimulus(0, 1, 0, gray5(5'(rc)));
      checkOutput($sformatf("wrap%0d full", k), 32'(bus.full), 32'd0);
      checkOutput($sformatf("wrap%0d wptr", k), 32'(bus.wptr), 32'(gray5(5'(k))));
      checkOutput($sformatf("wrap%0d wlevel", k), 32'(bus.wlevel), 32'(k - rc));
      checkOutput($sformatf("wrap%0d step", k), 32'($countones(prevPtr ^ bus.wptr)), 32'd1);
      prevPtr = bus.wptr;
    end
    checkOutput("wrap waddr", 32'(bus.waddr), 32'd8);

    // Full, a dropped write and a reader step all in the same cycle.
    applyStimulus(1, 0, 0, 5'b00000);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 1, 0, 5'b00000);
    end
    checkOutput("simul pre full", 32'(bus.full), 32'd1);
    bus.sync_rptr = 5'b00001;
    @(negedge wclk);
    checkOutput("simul wen", 32'(bus.wen), 32'd0);
    @(posedge wclk);
    #1;
    checkAll("simul", 5'b11000, 4'd0, 0, 1, 5'd15, 1);
    bus.winc = 1'b1;
    @(negedge wclk);
    checkOutput("simul next wen", 32'(bus.wen), 32'd1);
    @(posedge wclk);
    #1;
    checkAll("simul next", 5'b11001, 4'd1, 1, 1, 5'd16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
